// File: rtl/seven_segment_scan_driver_if.sv
// Bus between status logic and the seven-segment scan driver.
// master drives value/control, slave returns the display pin levels.
interface seven_segment_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    enable;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    blank_lz;
    logic [6:0]              seg_out;
    logic                    dp_out;
    logic [NUM_DIGITS-1:0]   an_out;
    logic [IW-1:0]           digit_idx;
    logic                    frame_done;

    modport master (
        output enable, load, value, dp_in, blank_lz,
        input  seg_out, dp_out, an_out, digit_idx, frame_done
    );

    modport slave (
        input  enable, load, value, dp_in, blank_lz,
        output seg_out, dp_out, an_out, digit_idx, frame_done
    );
endinterface

// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with blanking,
// leading-zero suppression and frame-aligned display updates.
module seven_segment_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter int BLANK_CYCLES   = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input logic clk,
    input logic rst_n,
    seven_segment_scan_driver_if.slave bus
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = $clog2(CLK_DIV);
    localparam int NW = 4 * NUM_DIGITS;

    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] BLK     = DW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_ACTIVE_LOW}};

    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] s;
        unique case (h)
            4'h0: s = 7'h7E;
            4'h1: s = 7'h30;
            4'h2: s = 7'h6D;
            4'h3: s = 7'h79;
            4'h4: s = 7'h33;
            4'h5: s = 7'h5B;
            4'h6: s = 7'h5F;
            4'h7: s = 7'h70;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h7B;
            4'hA: s = 7'h77;
            4'hB: s = 7'h1F;
            4'hC: s = 7'h4E;
            4'hD: s = 7'h3D;
            4'hE: s = 7'h4F;
            4'hF: s = 7'h47;
        endcase
        return s;
    endfunction

    logic [DW-1:0]         div_cnt;
    logic [IW-1:0]         idx;
    logic                  slot_end;
    logic                  wrap;
    logic                  xfer;

    logic [NW-1:0]         pend_val;
    logic [NUM_DIGITS-1:0] pend_dp;
    logic                  pend_ok;
    logic [NW-1:0]         disp_val;
    logic [NUM_DIGITS-1:0] disp_dp;

    logic [NUM_DIGITS-1:0] lz;
    logic                  lz_run;
    logic [3:0]            nib;
    logic                  lit;
    logic                  seg_on;
    logic [NUM_DIGITS-1:0] an_d;
    logic [6:0]            seg_d;
    logic                  dp_d;

    logic [NUM_DIGITS-1:0] an_q;
    logic [6:0]            seg_q;
    logic                  dp_q;
    logic                  fd_q;

    assign slot_end = (div_cnt == DIV_MAX);
    assign wrap     = bus.enable && slot_end && (idx == IDX_MAX);
    // While dark there is no frame to tear, so pending moves over at once
    assign xfer     = wrap || !bus.enable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (!bus.enable) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (slot_end) begin
            div_cnt <= '0;
            idx     <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val <= '0;
            pend_dp  <= '0;
            pend_ok  <= 1'b0;
            disp_val <= '0;
            disp_dp  <= '0;
        end else begin
            if (bus.load) begin
                pend_val <= bus.value;
                pend_dp  <= bus.dp_in;
            end
            if (bus.load && wrap) begin
                disp_val <= bus.value;
                disp_dp  <= bus.dp_in;
            end else if (pend_ok && xfer) begin
                disp_val <= pend_val;
                disp_dp  <= pend_dp;
            end
            pend_ok <= bus.load ? !wrap : (pend_ok && !xfer);
        end
    end

    // Digit i>0 is a leading zero when it and every digit above are zero
    always_comb begin
        lz_run = 1'b1;
        lz     = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_run = lz_run && (disp_val[4*i +: 4] == 4'h0);
            if (i > 0) lz[i] = lz_run;
        end
    end

    always_comb begin
        nib    = disp_val[{idx, 2'b00} +: 4];
        lit    = bus.enable && (div_cnt >= BLK);
        seg_on = bus.enable && !(bus.blank_lz && lz[idx]);
        an_d   = (lit ? (NUM_DIGITS'(1) << idx) : '0) ^ AN_OFF;
        seg_d  = (seg_on ? hex7(nib) : 7'h00) ^ SEG_OFF;
        dp_d   = (bus.enable && disp_dp[idx]) ^ DP_OFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q  <= AN_OFF;
            seg_q <= SEG_OFF;
            dp_q  <= DP_OFF;
            fd_q  <= 1'b0;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            fd_q  <= wrap;
        end
    end

    assign bus.an_out     = an_q;
    assign bus.seg_out    = seg_q;
    assign bus.dp_out     = dp_q;
    assign bus.frame_done = fd_q;
    assign bus.digit_idx  = idx;
endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Scoreboard bench for seven_segment_scan_driver: two polarity
// variants, directed frames checked by a decoupled monitor.
module tb_seven_segment_scan_driver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seven_segment_scan_driver_if #(.NUM_DIGITS(4)) ia ();
    seven_segment_scan_driver_if #(.NUM_DIGITS(4)) ib ();

    seven_segment_scan_driver #(
        .NUM_DIGITS(4), .CLK_DIV(4), .BLANK_CYCLES(1),
        .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1)
    ) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));

    seven_segment_scan_driver #(
        .NUM_DIGITS(4), .CLK_DIV(4), .BLANK_CYCLES(1),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b0)
    ) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        string      nm;
    } exp_t;

    exp_t q[$];
    exp_t e_m;
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int fd_last = 0;
    int fd_prev = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_frame(input string nm,
                              input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input logic [3:0] dp);
        logic [6:0] s[4];
        exp_t e;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int d = 0; d < 4; d++) begin
            e.an = 4'b1111;
            e.an[d] = 1'b0;
            e.seg = s[d];
            e.dp = dp[d];
            e.nm = $sformatf("%s.d%0d", nm, d);
            for (int k = 0; k < 3; k++) q.push_back(e);
        end
    endtask

    // Returns one cycle into the new frame, during its blank slot
    task automatic wait_frame();
        int n;
        n = 0;
        @(negedge clk);
        while (!ia.frame_done && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!ia.frame_done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_timeout: got none expected pulse");
        end
        fd_prev = fd_last;
        fd_last = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [15:0] v, input logic [3:0] dp);
        ia.load = 1'b1;
        ia.value = v;
        ia.dp_in = dp;
        @(posedge clk);
        #1;
        ia.load = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && ia.an_out != 4'hF && q.size() > 0) begin
            e_m = q.pop_front();
            chk({e_m.nm, ".an"}, 32'(ia.an_out), 32'(e_m.an));
            chk({e_m.nm, ".seg"}, 32'(ia.seg_out), 32'(e_m.seg));
            chk({e_m.nm, ".dp"}, 32'(ia.dp_out), 32'(e_m.dp));
        end
    end

    initial begin
        int n;
        ia.enable = 0; ia.load = 0; ia.value = '0;
        ia.dp_in = '0; ia.blank_lz = 0;
        ib.enable = 0; ib.load = 0; ib.value = '0;
        ib.dp_in = '0; ib.blank_lz = 0;

        repeat (2) @(negedge clk);
        chk("rst.an", 32'(ia.an_out), 32'hF);
        chk("rst.seg", 32'(ia.seg_out), 32'h00);
        chk("rst.dp", 32'(ia.dp_out), 32'h0);
        chk("rst.fd", 32'(ia.frame_done), 32'h0);
        chk("rst.idx", 32'(ia.digit_idx), 32'h0);
        chk("rstb.an", 32'(ib.an_out), 32'h0);
        chk("rstb.seg", 32'(ib.seg_out), 32'h7F);
        chk("rstb.dp", 32'(ib.dp_out), 32'h1);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ia.enable = 1'b1;
        load_a(16'h12AF, 4'b0000);

        wait_frame();
        push_frame("f12af", 7'h47, 7'h77, 7'h6D, 7'h30, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        load_a(16'h0000, 4'b0000);
        load_a(16'h8888, 4'b0000);

        wait_frame();
        chk("period1", 32'(fd_last - fd_prev), 32'd16);
        push_frame("f8888", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'b0000);
        ia.blank_lz = 1'b1;
        load_a(16'h0050, 4'b1000);

        wait_frame();
        chk("period2", 32'(fd_last - fd_prev), 32'd16);
        push_frame("flz", 7'h7E, 7'h5B, 7'h00, 7'h00, 4'b1000);
        repeat (14) @(posedge clk);
        #1;
        load_a(16'h3333, 4'b0000);

        wait_frame();
        chk("period3", 32'(fd_last - fd_prev), 32'd16);
        push_frame("fbyp", 7'h79, 7'h79, 7'h79, 7'h79, 4'b0000);
        wait_frame();

        repeat (5) @(posedge clk);
        #1;
        ia.enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("off.an", 32'(ia.an_out), 32'hF);
        chk("off.seg", 32'(ia.seg_out), 32'h00);
        chk("off.dp", 32'(ia.dp_out), 32'h0);
        chk("off.idx", 32'(ia.digit_idx), 32'h0);
        @(posedge clk);
        #1;
        load_a(16'h4444, 4'b0101);
        repeat (2) @(posedge clk);
        #1;
        chk("dark.an", 32'(ia.an_out), 32'hF);
        push_frame("fdark", 7'h33, 7'h33, 7'h33, 7'h33, 4'b0101);
        ia.enable = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        rst_n = 1'b0;
        #2;
        chk("arst.an", 32'(ia.an_out), 32'hF);
        chk("arst.seg", 32'(ia.seg_out), 32'h00);
        chk("arst.dp", 32'(ia.dp_out), 32'h0);
        chk("arst.q", 32'(q.size()), 32'd0);
        repeat (2) @(posedge clk);
        push_frame("fclr", 7'h7E, 7'h00, 7'h00, 7'h00, 4'b0000);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel.idx", 32'(ia.digit_idx), 32'h0);
        repeat (20) @(posedge clk);
        #1;
        chk("drain.q", 32'(q.size()), 32'd0);

        ib.enable = 1'b1;
        ib.load = 1'b1;
        ib.value = 16'h0001;
        @(posedge clk);
        #1;
        ib.load = 1'b0;
        n = 0;
        @(negedge clk);
        while (!ib.frame_done && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("b.fd", 32'(ib.frame_done), 32'h1);
        @(negedge clk);
        chk("b.idle_an", 32'(ib.an_out), 32'h0);
        @(negedge clk);
        chk("b.an", 32'(ib.an_out), 32'h1);
        chk("b.seg", 32'(ib.seg_out), 32'h4F);
        chk("b.dp", 32'(ib.dp_out), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
